// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, requests words from instruction memory, buffers them in a prefetch FIFO.
// Optional macro FETCH_BYPASS_EN forwards an ack straight to the datapath when the FIFO is empty.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   hold_addr_q, hold_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]   mem_instr_q [DEPTH];
  logic [15:0]   mem_pc_q    [DEPTH];

  logic fifo_valid;
  logic ack_live;
  logic bypass_taken;
  logic push;
  logic pop;

  assign fifo_valid = (count_q != '0);
  assign ack_live   = imem_ack && (state_q == REQ);

  always_comb begin
    instr_valid  = fifo_valid;
    instr        = mem_instr_q[rd_ptr_q];
    instr_pc     = mem_pc_q[rd_ptr_q];
    bypass_taken = 1'b0;
`ifdef FETCH_BYPASS_EN
    // An empty FIFO lets the word being acked reach the datapath in the same cycle.
    if (!fifo_valid && ack_live && !redirect) begin
      instr_valid  = 1'b1;
      instr        = imem_rdata;
      instr_pc     = imem_addr;
      bypass_taken = instr_ready;
    end
`endif
  end

  assign push = ack_live && !redirect && !bypass_taken;
  assign pop  = fifo_valid && instr_ready && !redirect;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    imem_req    = 1'b0;
    imem_addr   = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (count_q < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          // The outstanding request must still complete before the new target goes out.
          if (!imem_ack) begin
            state_d     = DISCARD;
            hold_addr_d = fetch_pc_q;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 16'd1;
          if (count_d >= DEPTH_C) state_d = IDLE;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = hold_addr_q;
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      if (push) begin
        mem_instr_q[wr_ptr_q] <= imem_rdata;
        mem_pc_q[wr_ptr_q]    <= imem_addr;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed sequences push expected words, a monitor pops and compares.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic        memOn = 1'b0;
  int          memWait = 0;
  int          waitCnt = 0;
  logic        memAck = 1'b0;
  logic [15:0] memData = '0;
  logic        manualAck = 1'b0;
  logic [15:0] manualData = '0;

  int compared = 0;
  int mismatched = 0;
  int ackCount = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;
  exp_t expQ[$];

  assign imem_ack   = memAck | manualAck;
  assign imem_rdata = manualAck ? manualData : memData;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory answers memWait cycles after seeing a request, with data = addr ^ A5A5.
  always @(posedge clk) begin
    #1;
    if (memOn && imem_req) begin
      if (waitCnt == memWait) begin
        memAck  = 1'b1;
        memData = imem_addr ^ 16'hA5A5;
        waitCnt = 0;
      end else begin
        memAck  = 1'b0;
        waitCnt = waitCnt + 1;
      end
    end else begin
      memAck  = 1'b0;
      waitCnt = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
    compared = compared + 1;
    if (actual !== required) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic pushExpected(input logic [15:0] pc);
    exp_t e;
    e.instr = pc ^ 16'hA5A5;
    e.pc    = pc;
    expQ.push_back(e);
  endtask

  // Monitor: every accepted head word must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && imem_req && imem_ack) ackCount = ackCount + 1;
    if (rst_n && instr_valid && instr_ready) begin
      if (expQ.size() == 0) begin
        compared   = compared + 1;
        mismatched = mismatched + 1;
        $display("[TB] FAIL unexpected_delivery: actual pc=%h instr=%h required none", instr_pc, instr);
      end else begin
        e = expQ.pop_front();
        checkOutput("deliver_pc", instr_pc, e.pc);
        checkOutput("deliver_instr", instr, e.instr);
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyReset();
    rst_n    = 1'b0;
    memOn    = 1'b0;
    memWait  = 0;
    redirect = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus();
    // Zero-wait streaming from reset.
    instr_ready = 1'b1;
    redirect_pc = 16'h0000;
    applyReset();
    checkOutput("reset_req", 16'(imem_req), 16'h0000);
    checkOutput("reset_addr", imem_addr, 16'h0000);
    checkOutput("reset_valid", 16'(instr_valid), 16'h0000);
    checkOutput("reset_instr", instr, 16'h0000);
    checkOutput("reset_instr_pc", instr_pc, 16'h0000);
    for (int i = 0; i < 8; i++) pushExpected(16'(i));
    memOn = 1'b1;
    stepCycle();
    checkOutput("first_req", 16'(imem_req), 16'h0001);
    checkOutput("first_addr", imem_addr, 16'h0000);
    repeat (7) stepCycle();
    memOn = 1'b0;
    repeat (4) stepCycle();
    checkOutput("stream_next_addr", imem_addr, 16'h0008);
    checkOutput("stream_queue_empty", 16'(expQ.size()), 16'h0000);

    // Back-pressure: FIFO fills with exactly DEPTH words.
    instr_ready = 1'b0;
    applyReset();
    memOn    = 1'b1;
    ackCount = 0;
    for (int i = 0; i < 4; i++) pushExpected(16'(i));
    repeat (12) stepCycle();
    checkOutput("full_ack_count", 16'(ackCount), 16'h0004);
    checkOutput("full_req", 16'(imem_req), 16'h0000);
    checkOutput("full_valid", 16'(instr_valid), 16'h0001);
    memOn       = 1'b0;
    instr_ready = 1'b1;
    repeat (8) stepCycle();
    checkOutput("resume_req", 16'(imem_req), 16'h0001);
    checkOutput("resume_addr", imem_addr, 16'h0004);

    // Redirect during a slow request: old address held, its data dropped.
    instr_ready = 1'b1;
    applyReset();
    memWait = 3;
    memOn   = 1'b1;
    pushExpected(16'h0040);
    stepCycle();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    stepCycle();
    redirect = 1'b0;
    checkOutput("discard_addr_w1", imem_addr, 16'h0000);
    checkOutput("discard_req", 16'(imem_req), 16'h0001);
    stepCycle();
    checkOutput("discard_addr_w2", imem_addr, 16'h0000);
    stepCycle();
    checkOutput("discard_addr_w3", imem_addr, 16'h0000);
    stepCycle();
    checkOutput("after_discard_addr", imem_addr, 16'h0040);
    repeat (5) stepCycle();
    memOn = 1'b0;
    repeat (4) stepCycle();

    // Redirect coinciding with an ack while the FIFO holds two words.
    instr_ready = 1'b0;
    applyReset();
    memOn = 1'b1;
    pushExpected(16'h0100);
    pushExpected(16'h0101);
    stepCycle();
    redirect    = 1'b1;
    redirect_pc = 16'h0005;
    stepCycle();
    redirect = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("two_held_valid", 16'(instr_valid), 16'h0001);
    checkOutput("two_held_head_pc", instr_pc, 16'h0005);
    checkOutput("two_held_addr", imem_addr, 16'h0007);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    stepCycle();
    redirect = 1'b0;
    checkOutput("flush_valid", 16'(instr_valid), 16'h0000);
    checkOutput("flush_addr", imem_addr, 16'h0100);
    instr_ready = 1'b1;
    stepCycle();
    memOn = 1'b0;
    repeat (4) stepCycle();

    // Fetch PC wraps from FFFF to 0000.
    instr_ready = 1'b1;
    applyReset();
    pushExpected(16'hFFFF);
    pushExpected(16'h0000);
    pushExpected(16'h0001);
    stepCycle();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    stepCycle();
    redirect = 1'b0;
    memOn    = 1'b1;
    repeat (4) stepCycle();
    memOn = 1'b0;
    repeat (4) stepCycle();
    checkOutput("wrap_next_addr", imem_addr, 16'h0002);

    // One-cycle reset with a request outstanding; the late ack lands in IDLE.
    rst_n = 1'b0;
    stepCycle();
    checkOutput("midreset_req", 16'(imem_req), 16'h0000);
    checkOutput("midreset_addr", imem_addr, 16'h0000);
    rst_n      = 1'b1;
    manualAck  = 1'b1;
    manualData = 16'h1234;
    stepCycle();
    manualAck = 1'b0;
    checkOutput("late_ack_valid", 16'(instr_valid), 16'h0000);
    checkOutput("late_ack_req", 16'(imem_req), 16'h0001);
    checkOutput("late_ack_addr", imem_addr, 16'h0000);
    repeat (3) stepCycle();
    checkOutput("late_ack_valid_hold", 16'(instr_valid), 16'h0000);

    checkOutput("scoreboard_drained", 16'(expQ.size()), 16'h0000);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
